// File: rtl/aes_pkg.sv
// Shared AES definitions: key-expansion sequencer state encoding, round/Rcon constants
// and the GF(2^8) xtime helper (also used by the MixColumns logic).
package aes_pkg;

   typedef enum logic [2:0] {
      KE_IDLE    = 3'd0,
      KE_LOAD    = 3'd1,
      KE_WAIT    = 3'd2,
      KE_PRESENT = 3'd3,
      KE_STEP    = 3'd4,
      KE_DONE    = 3'd5
   } ke_state_e;

   localparam logic [3:0] ROUND_LAST_C = 4'd10;
   localparam logic [7:0] RCON_FIRST_C = 8'h01;
   localparam logic [7:0] AES_POLY_C   = 8'h1B;

   function automatic logic [7:0] xtime(input logic [7:0] b);
      xtime = {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_C : 8'h00);
   endfunction

endpackage

// File: rtl/aes_rcon_gen.sv
// Round-constant register for AES-128 key expansion: clear to 0x00, advance 0x00 -> 0x01,
// then multiply by x in GF(2^8) on every further advance.
module aes_rcon_gen
   import aes_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clear,
   input  logic       advance,
   output logic [7:0] rcon
);

   logic [7:0] rcon_r;

   // Rcon state: clear wins over advance
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rcon_r <= 8'h00;
      end else if (clear) begin
         rcon_r <= 8'h00;
      end else if (advance) begin
         rcon_r <= (rcon_r == 8'h00) ? RCON_FIRST_C : xtime(rcon_r);
      end else begin
         rcon_r <= rcon_r;
      end
   end

   assign rcon = rcon_r;

endmodule

// File: rtl/aes_ke_ctrl.sv
// AES-128 key-expansion sequencer: load strobe, ten step strobes with Rcon, valid/ready
// round-key presentation. Optional AES_KE_CTRL_PERF_EN adds a saturating stall counter.
module aes_ke_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned KE_LAT     = 32'd1,
   parameter logic [3:0]  ROUND_LAST = ROUND_LAST_C
)(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start_in,
   input  logic        abort_in,
   input  logic        rk_ready_in,
   output logic        ke_load_out,
   output logic        ke_step_out,
   output logic [7:0]  rcon_out,
   output logic [3:0]  round_out,
   output logic        rk_valid_out,
   output logic        busy_out,
   output logic        done_out
`ifdef AES_KE_CTRL_PERF_EN
   ,
   output logic [15:0] stall_cnt_out
`endif
);

   localparam logic [2:0] WAIT_INIT_C = 3'(KE_LAT - 32'd1);

   ke_state_e  state_r, state_s;
   logic [2:0] cnt_r, cnt_s;
   logic [3:0] round_r, round_s;
   logic       rcon_clr_s, rcon_adv_s;

   aes_rcon_gen u_rcon (
      .clk     (clk),
      .rst_n   (rst_n),
      .clear   (rcon_clr_s),
      .advance (rcon_adv_s),
      .rcon    (rcon_out)
   );

   // Next-state, latency counter and round index; abort overrides every non-idle state
   always_comb begin
      state_s    = state_r;
      cnt_s      = cnt_r;
      round_s    = round_r;
      rcon_clr_s = 1'b0;
      rcon_adv_s = 1'b0;
      if ((state_r != KE_IDLE) && abort_in) begin
         state_s    = KE_IDLE;
         cnt_s      = 3'd0;
         round_s    = 4'd0;
         rcon_clr_s = 1'b1;
      end else begin
         case (state_r)
            KE_IDLE: begin
               if (start_in && !abort_in) begin
                  state_s    = KE_LOAD;
                  round_s    = 4'd0;
                  rcon_clr_s = 1'b1;
               end else begin
                  state_s = KE_IDLE;
               end
            end
            KE_LOAD, KE_STEP: begin
               if (KE_LAT == 32'd1) begin
                  state_s = KE_PRESENT;
               end else begin
                  state_s = KE_WAIT;
                  cnt_s   = WAIT_INIT_C;
               end
            end
            KE_WAIT: begin
               cnt_s = (cnt_r == 3'd0) ? 3'd0 : cnt_r - 3'd1;
               if (cnt_r <= 3'd1) begin
                  state_s = KE_PRESENT;
               end else begin
                  state_s = KE_WAIT;
               end
            end
            KE_PRESENT: begin
               if (!rk_ready_in) begin
                  state_s = KE_PRESENT;
               end else if (round_r < ROUND_LAST) begin
                  state_s    = KE_STEP;
                  round_s    = round_r + 4'd1;
                  rcon_adv_s = 1'b1;
               end else begin
                  state_s = KE_DONE;
               end
            end
            KE_DONE: begin
               state_s = KE_IDLE;
            end
            default: begin
               state_s    = KE_IDLE;
               cnt_s      = 3'd0;
               round_s    = 4'd0;
               rcon_clr_s = 1'b1;
            end
         endcase
      end
   end

   // State plus outputs decoded from the next state so every strobe leaves a flop
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= KE_IDLE;
         cnt_r        <= 3'd0;
         round_r      <= 4'd0;
         ke_load_out  <= 1'b0;
         ke_step_out  <= 1'b0;
         rk_valid_out <= 1'b0;
         busy_out     <= 1'b0;
         done_out     <= 1'b0;
      end else begin
         state_r      <= state_s;
         cnt_r        <= cnt_s;
         round_r      <= round_s;
         ke_load_out  <= (state_s == KE_LOAD);
         ke_step_out  <= (state_s == KE_STEP);
         rk_valid_out <= (state_s == KE_PRESENT);
         busy_out     <= (state_s != KE_IDLE);
         done_out     <= (state_s == KE_DONE);
      end
   end

   assign round_out = round_r;

`ifdef AES_KE_CTRL_PERF_EN
   logic [15:0] stall_r;
   logic        start_ok_s;

   assign start_ok_s = (state_r == KE_IDLE) && start_in && !abort_in;

   // Saturating count of presented-but-not-accepted cycles, cleared per expansion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stall_r <= 16'd0;
      end else if (start_ok_s) begin
         stall_r <= 16'd0;
      end else if (rk_valid_out && !rk_ready_in && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'd1;
      end else begin
         stall_r <= stall_r;
      end
   end

   assign stall_cnt_out = stall_r;
`endif

endmodule

// File: tb/tb_aes_ke_ctrl.sv
// Self-checking bench for aes_ke_ctrl: KE_LAT=1 and KE_LAT=3 instances on shared stimulus,
// round keys checked against a scoreboard of expected (round, rcon) pairs.
`timescale 1ns/1ps
module tb_aes_ke_ctrl;

   localparam int unsigned LAT3 = 3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start_in = 1'b0;
   logic abort_in = 1'b0;
   logic rk_ready_in = 1'b1;

   logic       ke_load_out, ke_step_out, rk_valid_out, busy_out, done_out;
   logic [7:0] rcon_out;
   logic [3:0] round_out;
   logic       s3_load, s3_step, s3_valid, s3_busy, s3_done;
   logic [7:0] s3_rcon;
   logic [3:0] s3_round;
`ifdef AES_KE_CTRL_PERF_EN
   logic [15:0] stall_cnt_out, s3_stall;
`endif

   typedef struct packed {
      logic [3:0] round;
      logic [7:0] rcon;
   } rk_t;

   rk_t        sb_q[$];
   logic [7:0] rcon_tab [0:10];
   int         errors = 0;
   int         checks = 0;

   always #5 clk = ~clk;

   aes_ke_ctrl #(.KE_LAT(1)) dut (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
      .rk_ready_in(rk_ready_in), .ke_load_out(ke_load_out), .ke_step_out(ke_step_out),
      .rcon_out(rcon_out), .round_out(round_out), .rk_valid_out(rk_valid_out),
      .busy_out(busy_out), .done_out(done_out)
`ifdef AES_KE_CTRL_PERF_EN
      , .stall_cnt_out(stall_cnt_out)
`endif
   );

   aes_ke_ctrl #(.KE_LAT(LAT3)) dut3 (
      .clk(clk), .rst_n(rst_n), .start_in(start_in), .abort_in(abort_in),
      .rk_ready_in(rk_ready_in), .ke_load_out(s3_load), .ke_step_out(s3_step),
      .rcon_out(s3_rcon), .round_out(s3_round), .rk_valid_out(s3_valid),
      .busy_out(s3_busy), .done_out(s3_done)
`ifdef AES_KE_CTRL_PERF_EN
      , .stall_cnt_out(s3_stall)
`endif
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_all();
      @(negedge clk);
      abort_in = 1'b1;
      start_in = 1'b0;
      rk_ready_in = 1'b1;
      @(negedge clk);
      abort_in = 1'b0;
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if ({ke_load_out, ke_step_out, rk_valid_out, busy_out, done_out, round_out, rcon_out} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outs: got %0h required 0", {ke_load_out, ke_step_out, rk_valid_out, busy_out, done_out, round_out, rcon_out});
      end
      checks++;
      if ({s3_load, s3_step, s3_valid, s3_busy, s3_done, s3_round, s3_rcon} !== 17'd0) begin
         errors++;
         $display("FAIL reset_outs3: got %0h required 0", {s3_load, s3_step, s3_valid, s3_busy, s3_done, s3_round, s3_rcon});
      end
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      tick();
      checks++;
      if (busy_out !== 1'b0 || ke_load_out !== 1'b0) begin
         errors++;
         $display("FAIL reset_idle: busy=%0b load=%0b required 0 0", busy_out, ke_load_out);
      end
   endtask

   task automatic test_sequence();
      rk_t exp;
      sb_q.delete();
      for (int r = 0; r <= 10; r++) sb_q.push_back('{round: 4'(r), rcon: rcon_tab[r]});
      @(negedge clk);
      start_in = 1'b1;
      rk_ready_in = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         tick();
         if (e == 1) start_in = 1'b0;
         checks++;
         if (ke_load_out !== (e == 1)) begin
            errors++; $display("FAIL seq_load e=%0d: got %0b", e, ke_load_out);
         end
         checks++;
         if (ke_step_out !== (e >= 3 && e <= 21 && (e % 2) == 1)) begin
            errors++; $display("FAIL seq_step e=%0d: got %0b", e, ke_step_out);
         end
         checks++;
         if (rk_valid_out !== (e >= 2 && e <= 22 && (e % 2) == 0)) begin
            errors++; $display("FAIL seq_valid e=%0d: got %0b", e, rk_valid_out);
         end
         checks++;
         if (done_out !== (e == 23)) begin
            errors++; $display("FAIL seq_done e=%0d: got %0b", e, done_out);
         end
         checks++;
         if (busy_out !== (e <= 23)) begin
            errors++; $display("FAIL seq_busy e=%0d: got %0b", e, busy_out);
         end
         if (ke_step_out) begin
            checks++;
            if (rcon_out !== rcon_tab[(e - 1) / 2]) begin
               errors++; $display("FAIL seq_step_rcon e=%0d: got %0h required %0h", e, rcon_out, rcon_tab[(e - 1) / 2]);
            end
         end
         if (rk_valid_out && rk_ready_in) begin
            checks++;
            if (sb_q.size() == 0) begin
               errors++; $display("FAIL seq_extra_key e=%0d: round %0d", e, round_out);
            end else begin
               exp = sb_q.pop_front();
               if ({round_out, rcon_out} !== exp) begin
                  errors++; $display("FAIL seq_key e=%0d: got %0h required %0h", e, {round_out, rcon_out}, exp);
               end
            end
         end
      end
      checks++;
      if (sb_q.size() != 0) begin
         errors++; $display("FAIL seq_missing_keys: %0d left required 0", sb_q.size());
      end
   endtask

   task automatic test_stall();
      bit found = 1'b0;
      idle_all();
      @(negedge clk);
      start_in = 1'b1;
      rk_ready_in = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         start_in = 1'b0;
         if (rk_valid_out && round_out == 4'd3) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL stall_timeout: round 3 never presented");
      end else begin
         rk_ready_in = 1'b0;
         for (int i = 1; i <= 5; i++) begin
            tick();
            checks++;
            if ({rk_valid_out, ke_step_out, round_out, rcon_out} !== {1'b1, 1'b0, 4'd3, 8'h04}) begin
               errors++; $display("FAIL stall_hold c=%0d: got %0h required %0h", i, {rk_valid_out, ke_step_out, round_out, rcon_out}, {1'b1, 1'b0, 4'd3, 8'h04});
            end
         end
`ifdef AES_KE_CTRL_PERF_EN
         checks++;
         if (stall_cnt_out !== 16'd5) begin
            errors++; $display("FAIL stall_cnt: got %0d required 5", stall_cnt_out);
         end
`endif
         rk_ready_in = 1'b1;
         tick();
         checks++;
         if ({ke_step_out, round_out, rcon_out} !== {1'b1, 4'd4, 8'h08}) begin
            errors++; $display("FAIL stall_resume: got %0h required %0h", {ke_step_out, round_out, rcon_out}, {1'b1, 4'd4, 8'h08});
         end
`ifdef AES_KE_CTRL_PERF_EN
         checks++;
         if (stall_cnt_out !== 16'd5) begin
            errors++; $display("FAIL stall_cnt_hold: got %0d required 5", stall_cnt_out);
         end
`endif
      end
   endtask

   task automatic test_lat3();
      int strobe_e = -100;
      int nvalid = 0;
      int done_e = 1 + int'(LAT3) + 10 * (int'(LAT3) + 1) + 1;
      idle_all();
      @(negedge clk);
      start_in = 1'b1;
      rk_ready_in = 1'b1;
      for (int e = 1; e <= done_e + 2; e++) begin
         tick();
         if (e == 1) start_in = 1'b0;
         if (s3_load || s3_step) strobe_e = e;
         if (s3_valid) begin
            nvalid++;
            checks++;
            if (e - strobe_e != int'(LAT3)) begin
               errors++; $display("FAIL lat3_latency e=%0d: got %0d required %0d", e, e - strobe_e, LAT3);
            end
         end
         checks++;
         if (s3_done !== (e == done_e)) begin
            errors++; $display("FAIL lat3_done e=%0d: got %0b", e, s3_done);
         end
      end
      checks++;
      if (nvalid != 11) begin
         errors++; $display("FAIL lat3_keys: got %0d required 11", nvalid);
      end
   endtask

   task automatic test_abort();
      bit found = 1'b0;
      idle_all();
      @(negedge clk);
      start_in = 1'b1;
      for (int i = 0; i < 30 && !found; i++) begin
         tick();
         start_in = 1'b0;
         if (rk_valid_out && round_out == 4'd5) found = 1'b1;
      end
      checks++;
      if (!found || rcon_out !== 8'h10) begin
         errors++; $display("FAIL abort_pre: found=%0b rcon=%0h required 1 10", found, rcon_out);
      end
      abort_in = 1'b1;
      tick();
      abort_in = 1'b0;
      checks++;
      if ({busy_out, rk_valid_out, done_out, ke_load_out, ke_step_out, round_out, rcon_out} !== 17'd0) begin
         errors++; $display("FAIL abort_idle: got %0h required 0", {busy_out, rk_valid_out, done_out, ke_load_out, ke_step_out, round_out, rcon_out});
      end
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (done_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL abort_no_done: done=%0b busy=%0b required 0 0", done_out, busy_out);
         end
      end
      @(negedge clk);
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      checks++;
      if ({ke_load_out, round_out, rcon_out} !== {1'b1, 4'd0, 8'h00}) begin
         errors++; $display("FAIL abort_restart_load: got %0h required %0h", {ke_load_out, round_out, rcon_out}, {1'b1, 4'd0, 8'h00});
      end
      tick();
      checks++;
      if ({rk_valid_out, round_out, rcon_out} !== {1'b1, 4'd0, 8'h00}) begin
         errors++; $display("FAIL abort_restart_key: got %0h required %0h", {rk_valid_out, round_out, rcon_out}, {1'b1, 4'd0, 8'h00});
      end
   endtask

   task automatic test_start_ignored();
      idle_all();
      @(negedge clk);
      start_in = 1'b1;
      for (int e = 1; e <= 25; e++) begin
         tick();
         start_in = (e == 5);
         if (e == 5) begin
            checks++;
            if (ke_step_out !== 1'b1 || round_out !== 4'd2) begin
               errors++; $display("FAIL ign_pre: step=%0b round=%0d required 1 2", ke_step_out, round_out);
            end
         end
         checks++;
         if (ke_load_out !== (e == 1) || done_out !== (e == 23) || busy_out !== (e <= 23)) begin
            errors++; $display("FAIL ign_seq e=%0d: load=%0b done=%0b busy=%0b", e, ke_load_out, done_out, busy_out);
         end
      end
      @(negedge clk);
      start_in = 1'b1;
      abort_in = 1'b1;
      tick();
      start_in = 1'b0;
      abort_in = 1'b0;
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (ke_load_out !== 1'b0 || busy_out !== 1'b0) begin
            errors++; $display("FAIL ign_abort_prio c=%0d: load=%0b busy=%0b required 0 0", i, ke_load_out, busy_out);
         end
         tick();
      end
   endtask

   task automatic test_async_reset();
      bit found = 1'b0;
      idle_all();
      @(negedge clk);
      start_in = 1'b1;
      for (int i = 0; i < 60 && !found; i++) begin
         tick();
         start_in = 1'b0;
         if (s3_step && s3_round == 4'd7) found = 1'b1;
      end
      checks++;
      if (!found) begin
         errors++; $display("FAIL areset_timeout: round 7 step never seen");
      end else begin
         tick();
         checks++;
         if (s3_busy !== 1'b1 || s3_valid !== 1'b0 || s3_step !== 1'b0) begin
            errors++; $display("FAIL areset_pre: busy=%0b valid=%0b step=%0b required 1 0 0", s3_busy, s3_valid, s3_step);
         end
         #2;
         rst_n = 1'b0;
         #1;
         checks++;
         if ({s3_load, s3_step, s3_valid, s3_busy, s3_done, s3_round, s3_rcon} !== 17'd0) begin
            errors++; $display("FAIL areset_outs3: got %0h required 0", {s3_load, s3_step, s3_valid, s3_busy, s3_done, s3_round, s3_rcon});
         end
         checks++;
         if ({ke_load_out, ke_step_out, rk_valid_out, busy_out, done_out, round_out, rcon_out} !== 17'd0) begin
            errors++; $display("FAIL areset_outs: got %0h required 0", {ke_load_out, ke_step_out, rk_valid_out, busy_out, done_out, round_out, rcon_out});
         end
         @(negedge clk);
         rst_n = 1'b1;
         for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s3_busy !== 1'b0 || s3_load !== 1'b0 || busy_out !== 1'b0) begin
               errors++; $display("FAIL areset_idle c=%0d: busy3=%0b load3=%0b busy=%0b", i, s3_busy, s3_load, busy_out);
            end
         end
         @(negedge clk);
         start_in = 1'b1;
         tick();
         start_in = 1'b0;
         checks++;
         if (s3_load !== 1'b1 || ke_load_out !== 1'b1 || s3_round !== 4'd0) begin
            errors++; $display("FAIL areset_restart: load3=%0b load=%0b round3=%0d required 1 1 0", s3_load, ke_load_out, s3_round);
         end
      end
   endtask

   initial begin
      rcon_tab[0] = 8'h00; rcon_tab[1] = 8'h01; rcon_tab[2]  = 8'h02;
      rcon_tab[3] = 8'h04; rcon_tab[4] = 8'h08; rcon_tab[5]  = 8'h10;
      rcon_tab[6] = 8'h20; rcon_tab[7] = 8'h40; rcon_tab[8]  = 8'h80;
      rcon_tab[9] = 8'h1B; rcon_tab[10] = 8'h36;
      test_reset();
      test_sequence();
      test_stall();
      test_lat3();
      test_abort();
      test_start_ignored();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not finish within 100us");
      $fatal(1, "watchdog expired");
   end

endmodule
